puf_response_sampler: RTL and testbench

Control and capture stage downstream of the arbiter-PUF switch chain. It holds a challenge on the chain select lines and fires repeated launch edges into both chain inputs. For each trial it samples the arbiter latch output through a 2-flop synchronizer and majority-votes over the trials. It then delivers one response bit, the raw ones count and a stability flag over a valid/ready handshake.

---
 rtl/puf_response_sampler.sv | 151 +++++++++++++++
 tb/tb_puf_response_sampler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/puf_response_sampler.sv
// Arbiter-PUF control/capture stage: holds a challenge, fires NUM_TRIALS launch
// pulses, samples the synchronized arbiter output per trial and majority-votes.
module puf_response_sampler #(
    parameter int CHAL_W        = 64,
    parameter int SETTLE_CYCLES = 8,
    parameter int NUM_TRIALS    = 15,
    parameter int CNT_W         = $clog2(NUM_TRIALS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic [CHAL_W-1:0] chal_out,
    output logic              launch,
    input  logic              arb_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_bit,
    output logic [CNT_W-1:0]  ones_count,
    output logic              stable,
    output logic [1:0]        dbg_state
);
    // Cycle counter only needs to reach SETTLE_CYCLES+1 (last HIGH cycle).
    localparam int CYC_W = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CYC_W-1:0] LOW_LAST   = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] HIGH_LAST  = CYC_W'(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TRIAL_LAST = CNT_W'(NUM_TRIALS - 1);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(NUM_TRIALS / 2);
    localparam logic [CNT_W-1:0] ALL        = CNT_W'(NUM_TRIALS);

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   trial_q, trial_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic [CNT_W-1:0]   ones_sum;
    logic               sync1_q, sync2_q;
    logic [CHAL_W-1:0]  chal_q, chal_d;
    logic               launch_q, launch_d;
    logic               valid_q, valid_d;
    logic               bit_q, bit_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               stable_q, stable_d;

    assign ones_sum = ones_q + CNT_W'(sync2_q);

    // Response handshake: resp_valid rises on entry to DONE and the response
    // fields are frozen until the edge where resp_valid && resp_ready, which
    // drops resp_valid and returns to IDLE; start is ignored outside IDLE.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        trial_d  = trial_q;
        ones_d   = ones_q;
        chal_d   = chal_q;
        launch_d = 1'b0;
        valid_d  = valid_q;
        bit_d    = bit_q;
        count_d  = count_q;
        stable_d = stable_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOW;
                    chal_d  = challenge;
                    cyc_d   = '0;
                    trial_d = '0;
                    ones_d  = '0;
                end
            end
            ST_LOW: begin
                if (cyc_q == LOW_LAST) begin
                    state_d  = ST_HIGH;
                    cyc_d    = '0;
                    launch_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_HIGH: begin
                launch_d = 1'b1;
                if (cyc_q == HIGH_LAST) begin
                    launch_d = 1'b0;
                    cyc_d    = '0;
                    ones_d   = ones_sum;
                    if (trial_q == TRIAL_LAST) begin
                        state_d  = ST_DONE;
                        valid_d  = 1'b1;
                        bit_d    = (ones_sum > HALF);
                        count_d  = ones_sum;
                        stable_d = (ones_sum == '0) || (ones_sum == ALL);
                    end else begin
                        state_d = ST_LOW;
                        trial_d = trial_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            trial_q  <= '0;
            ones_q   <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            chal_q   <= '0;
            launch_q <= 1'b0;
            valid_q  <= 1'b0;
            bit_q    <= 1'b0;
            count_q  <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            trial_q  <= trial_d;
            ones_q   <= ones_d;
            sync1_q  <= arb_in;
            sync2_q  <= sync1_q;
            chal_q   <= chal_d;
            launch_q <= launch_d;
            valid_q  <= valid_d;
            bit_q    <= bit_d;
            count_q  <= count_d;
            stable_q <= stable_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign chal_out   = chal_q;
    assign launch     = launch_q;
    assign resp_valid = valid_q;
    assign resp_bit   = bit_q;
    assign ones_count = count_q;
    assign stable     = stable_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_puf_response_sampler.sv
// Randomized bench for puf_response_sampler: a per-run reference computes the
// expected launch waveform, handshake window and majority result.
module tb_puf_response_sampler;
  localparam int CHAL_W = 64;
  localparam int S      = 8;
  localparam int N      = 15;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int PER    = 2 * S + 2;
  localparam int LAT    = N * PER;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CHAL_W-1:0] challenge = '0;
  logic              busy;
  logic [CHAL_W-1:0] chal_out;
  logic              launch;
  logic              arb_in = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_bit;
  logic [CNT_W-1:0]  ones_count;
  logic              stable;
  logic [1:0]        dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  logic [CNT_W+1:0] exp_q[$];

  puf_response_sampler #(
    .CHAL_W(CHAL_W), .SETTLE_CYCLES(S), .NUM_TRIALS(N)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .busy(busy),
    .chal_out(chal_out), .launch(launch), .arb_in(arb_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bit(resp_bit),
    .ones_count(ones_count), .stable(stable), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_launch"}, launch, 0);
    check_eq({tag, "_chal"}, chal_out, 0);
    check_eq({tag, "_valid"}, resp_valid, 0);
    check_eq({tag, "_bit"}, resp_bit, 0);
    check_eq({tag, "_count"}, ones_count, 0);
    check_eq({tag, "_stable"}, stable, 0);
  endtask

  // One measurement. n_ones<0: random trial bits. ready_wait: cycles of
  // backpressure after valid. poke: start retries while busy. abort_at: edge
  // at which rst is applied (<0 for none).
  task automatic do_run(input logic [CHAL_W-1:0] chal, input int n_ones,
                        input int ready_wait, input bit poke, input int abort_at);
    int hs;
    int exp_ones;
    int idx;
    int tmp;
    int j;
    bit exp_launch, exp_valid, exp_busy, exp_bit, exp_stable;
    int t[N];
    bit drv[];
    logic [CNT_W+1:0] got_resp, exp_resp;
    hs = LAT + ready_wait + 1;
    drv = new[hs + 4];
    for (int k = 0; k < N; k++) t[k] = (n_ones < 0) ? int'($urandom_range(0, 1)) : int'(k < n_ones);
    if (n_ones >= 0)
      for (int k = N - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = t[k]; t[k] = t[j]; t[j] = tmp;
      end
    for (int c = 0; c < hs + 4; c++)
      drv[c] = (n_ones == N) ? 1'b1 : (n_ones == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    // arb_in driven after edge c is seen by the accumulator at edge c+3
    for (int k = 0; k < N; k++) drv[(k + 1) * PER - 3] = t[k][0];
    exp_ones = 0;
    for (int k = 0; k < N; k++) exp_ones += int'(drv[(k + 1) * PER - 3]);
    exp_bit = (exp_ones > N / 2);
    exp_stable = (exp_ones == 0) || (exp_ones == N);
    if (abort_at < 0) exp_q.push_back({exp_stable, exp_bit, CNT_W'(exp_ones)});

    @(negedge clk);
    start = 1'b1;
    challenge = chal;
    resp_ready = (ready_wait == 0);
    arb_in = (n_ones == N);
    for (int c = 0; c <= hs + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      challenge = {$urandom, $urandom};
      if (abort_at >= 0 && c == abort_at) begin
        rst = 1'b0;
        check_reset_outputs("abort");
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_eq("abort_idle_valid", resp_valid, 0);
          check_eq("abort_idle_launch", launch, 0);
        end
        return;
      end
      exp_busy = (c < hs);
      exp_valid = (c >= LAT) && (c < hs);
      exp_launch = (c < LAT) && ((c % PER) >= S);
      check_eq("busy", busy, exp_busy);
      check_eq("launch", launch, exp_launch);
      check_eq("resp_valid", resp_valid, exp_valid);
      check_eq("chal_out", chal_out, chal);
      if (exp_valid) begin
        check_eq("resp_bit", resp_bit, exp_bit);
        check_eq("ones_count", ones_count, exp_ones);
        check_eq("stable", stable, exp_stable);
      end
      if (c == hs - 1) begin
        check_eq("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_resp = exp_q.pop_front();
          got_resp = {stable, resp_bit, ones_count};
          check_eq("scoreboard", got_resp, exp_resp);
        end
      end
      idx = c;
      arb_in = drv[idx];
      resp_ready = (ready_wait == 0) || (c + 1 >= hs);
      if (poke && (c + 1 == 5 || c + 1 == 100 || c + 1 == hs)) begin
        start = 1'b1;
        challenge = ~chal;
      end
      if (abort_at >= 0 && c + 1 == abort_at) rst = 1'b1;
    end
    start = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    // reset with start high and arb_in toggling
    start = 1'b1;
    challenge = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      arb_in = ~arb_in;
      check_reset_outputs("reset");
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("post_reset_busy", busy, 0);

    do_run(64'hA5A5_0000_FFFF_1234, N, 0, 1'b0, -1);
    do_run({$urandom, $urandom}, 8, 0, 1'b0, -1);
    do_run({$urandom, $urandom}, 7, 0, 1'b0, -1);
    do_run({$urandom, $urandom}, 0, 0, 1'b0, -1);
    do_run({$urandom, $urandom}, -1, 20, 1'b0, -1);
    do_run({$urandom, $urandom}, -1, 0, 1'b1, -1);
    do_run({$urandom, $urandom}, -1, 0, 1'b0, 137);
    do_run({$urandom, $urandom}, -1, 0, 1'b0, -1);
    for (int r = 0; r < 3; r++)
      do_run({$urandom, $urandom}, $urandom_range(1, N - 1), $urandom_range(0, 5), 1'b0, -1);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
